ex_operand_stage: RTL and testbench
===================================

// Module: ex_operand_stage
// PURPOSE
//  ID/EX pipeline register directly upstream of the ALU: captures decoded ops, resolves RAW hazards
//  via MEM/WB forwarding, detects load-use hazards (1-cycle bubble), drives ALU A/B/ALUFun/Sign.
//  Also supplies forwarded store data and a saturating stall counter for performance debug.
// PARAMETERS
//  DATA_W  32  operand/result width
//  REG_AW  5   register address width
//  CNT_W   16  stall counter width
// PORTS
//  clk            in   1       rising-edge clock
//  reset          in   1       asynchronous, active-low reset
//  id_valid       in   1       ID holds a real instruction
//  id_rs_addr     in   REG_AW  rs index
//  id_rt_addr     in   REG_AW  rt index
//  id_rs_data     in   DATA_W  regfile rs read
//  id_rt_data     in   DATA_W  regfile rt read
//  id_imm         in   DATA_W  extended immediate
//  id_shamt       in   5       shift amount
//  id_alusrc_a    in   1       1: A = zero-extended shamt
//  id_alusrc_b    in   1       1: B = imm
//  id_alufun      in   6       ALU function code
//  id_sign        in   1       signed compare/overflow
//  id_rd_addr     in   REG_AW  destination index
//  id_regwrite    in   1       writes rd
//  id_memread     in   1       instruction is a load
//  flush          in   1       kill ID->EX transfer (branch/jump)
//  stall_in       in   1       downstream hold request
//  mem_regwrite   in   1       EX/MEM writes rd
//  mem_memread    in   1       EX/MEM is a load
//  mem_rd_addr    in   REG_AW  EX/MEM destination
//  mem_result     in   DATA_W  EX/MEM ALU result
//  wb_regwrite    in   1       MEM/WB writes rd
//  wb_rd_addr     in   REG_AW  MEM/WB destination
//  wb_result      in   DATA_W  MEM/WB writeback value
//  ex_valid       out  1       EX holds real instruction
//  alu_a          out  DATA_W  ALU A (shift amount on A[4:0])
//  alu_b          out  DATA_W  ALU B
//  alu_fun        out  6       to ALU ALUFun
//  alu_sign       out  1       to ALU Sign
//  ex_store_data  out  DATA_W  forwarded rt for stores
//  ex_rd_addr     out  REG_AW  destination
//  ex_regwrite    out  1       gated by ex_valid
//  ex_memread     out  1       gated by ex_valid
//  id_stall       out  1       hold PC and IF/ID
//  stall_cnt      out  CNT_W   cycles with id_stall=1, saturating
// BEHAVIOUR
//  Reset (reset=0, async): all registers 0; ex_valid=0, alu_fun=0, all outputs 0, stall_cnt=0.
//  Capture priority at posedge: flush > stall_in > load-use > normal.
//   flush: ex_valid<=0, control regs 0 (regardless of stall_in).
//   stall_in: hold all fields; stored rs/rt data refreshed with current forwarded values (keeps
//    operands valid while producer retires during hold).
//   load-use: ex_valid&ex_memread&ex_rd_addr!=0&id_valid&(id_rs==ex_rd|id_rt==ex_rd) -> bubble.
//   normal: load ID fields; ex_valid<=id_valid.
//  id_stall = stall_in | load-use (combinational). Load-use lasts 1 cycle; the load then sits in MEM/WB
//   and is forwarded from wb_*.
//  Capture-time WB bypass: wb_regwrite & wb_rd_addr==id_rs(rt) & !=0 -> capture wb_result.
//  EX forwarding (combinational, per stored rs/rt): MEM hit (mem_regwrite & !mem_memread & rd match
//   & rd!=0) wins over WB hit; else stored data. Register 0 never forwarded.
//  alu_a = alusrc_a ? {27'b0,shamt} : fwd_rs; alu_b = alusrc_b ? imm : fwd_rt; ex_store_data=fwd_rt.
//  ex_valid=0 -> alu_a, alu_b, ex_store_data, alu_fun, alu_sign, ex_regwrite, ex_memread driven 0.
//  Latency: 1 cycle ID->EX; forwarding adds no cycle. stall_cnt saturates at all-ones, no wrap.
// TESTING
//  reset low mid-stream with ex_valid=1 -> all outputs 0 same cycle, stay 0 until first capture.
//  MEM rd=5 0x1234 & WB rd=5 0xBEEF, ID add rs=5 data 0 -> next cycle alu_a=0x1234 (MEM priority).
//  mem_rd=0 regwrite 0xFFFF, ID rs=0 -> alu_a=0; sll shamt=4 rt=1 -> alu_a=4, alu_b=1.
//  EX lw r8, ID add rs=8 -> id_stall=1 one cycle, ex_valid=0, then add enters with alu_a=wb_result.
//  stall_in 3 cycles while WB r9=0x77 retires, EX uses r9 -> after release alu_a=0x77.
//  flush&stall_in same cycle -> ex_valid=0; id_stall held 2^CNT_W+2 cycles -> stall_cnt all-ones.

Source files
------------

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register that feeds the ALU. It resolves RAW hazards by forwarding from MEM/WB,
// inserts a one-cycle bubble on load-use, and counts stalled cycles for performance debug.
module ex_operand_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs_addr,
    input  logic [REG_AW-1:0] id_rt_addr,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [4:0]        id_shamt,
    input  logic              id_alusrc_a,
    input  logic              id_alusrc_b,
    input  logic [5:0]        id_alufun,
    input  logic              id_sign,
    input  logic [REG_AW-1:0] id_rd_addr,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              flush,
    input  logic              stall_in,
    input  logic              mem_regwrite,
    input  logic              mem_memread,
    input  logic [REG_AW-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_regwrite,
    input  logic [REG_AW-1:0] wb_rd_addr,
    input  logic [DATA_W-1:0] wb_result,
    output logic              ex_valid,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [5:0]        alu_fun,
    output logic              alu_sign,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_AW-1:0] ex_rd_addr,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic              id_stall,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [REG_AW-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [REG_AW-1:0] rs_addr;
        logic [REG_AW-1:0] rt_addr;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [4:0]        shamt;
        logic              alusrc_a;
        logic              alusrc_b;
        logic [5:0]        alufun;
        logic              sign;
        logic [REG_AW-1:0] rd_addr;
        logic              regwrite;
        logic              memread;
    } ex_fields_t;

    ex_fields_t        ex_q;
    ex_fields_t        ex_d;
    logic              ex_valid_q;
    logic              ex_valid_d;
    logic              load_use;
    logic              mem_hit_rs;
    logic              mem_hit_rt;
    logic              wb_hit_rs;
    logic              wb_hit_rt;
    logic              wb_byp_rs;
    logic              wb_byp_rt;
    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;
    logic [DATA_W-1:0] cap_rs;
    logic [DATA_W-1:0] cap_rt;
    logic [CNT_W-1:0]  stall_cnt_q;

    // A load still in EX cannot forward yet, so a dependent instruction in ID waits one cycle.
    always_comb begin
        load_use = ex_valid_q && ex_q.memread && (ex_q.rd_addr != ZERO_REG) && id_valid &&
                   ((id_rs_addr == ex_q.rd_addr) || (id_rt_addr == ex_q.rd_addr));
    end

    assign id_stall = stall_in | load_use;

    // Loads in MEM have no data yet, so only non-load MEM results are forwarded.
    always_comb begin
        mem_hit_rs = mem_regwrite && !mem_memread && (mem_rd_addr == ex_q.rs_addr) &&
                     (ex_q.rs_addr != ZERO_REG);
        mem_hit_rt = mem_regwrite && !mem_memread && (mem_rd_addr == ex_q.rt_addr) &&
                     (ex_q.rt_addr != ZERO_REG);
        wb_hit_rs  = wb_regwrite && (wb_rd_addr == ex_q.rs_addr) && (ex_q.rs_addr != ZERO_REG);
        wb_hit_rt  = wb_regwrite && (wb_rd_addr == ex_q.rt_addr) && (ex_q.rt_addr != ZERO_REG);

        fwd_rs = ex_q.rs_data;
        if (mem_hit_rs) begin
            fwd_rs = mem_result;
        end else if (wb_hit_rs) begin
            fwd_rs = wb_result;
        end

        fwd_rt = ex_q.rt_data;
        if (mem_hit_rt) begin
            fwd_rt = mem_result;
        end else if (wb_hit_rt) begin
            fwd_rt = wb_result;
        end
    end

    // The register file is read before the WB write lands, so bypass WB into the captured operands.
    always_comb begin
        wb_byp_rs = wb_regwrite && (wb_rd_addr == id_rs_addr) && (id_rs_addr != ZERO_REG);
        wb_byp_rt = wb_regwrite && (wb_rd_addr == id_rt_addr) && (id_rt_addr != ZERO_REG);
        cap_rs    = wb_byp_rs ? wb_result : id_rs_data;
        cap_rt    = wb_byp_rt ? wb_result : id_rt_data;
    end

    always_comb begin
        ex_d       = ex_q;
        ex_valid_d = ex_valid_q;
        if (flush || (!stall_in && load_use)) begin
            ex_d       = '0;
            ex_valid_d = 1'b0;
        end else if (stall_in) begin
            // Refresh held operands so a producer retiring during the hold is not lost.
            ex_d.rs_data = fwd_rs;
            ex_d.rt_data = fwd_rt;
        end else begin
            ex_valid_d     = id_valid;
            ex_d.rs_addr   = id_rs_addr;
            ex_d.rt_addr   = id_rt_addr;
            ex_d.rs_data   = cap_rs;
            ex_d.rt_data   = cap_rt;
            ex_d.imm       = id_imm;
            ex_d.shamt     = id_shamt;
            ex_d.alusrc_a  = id_alusrc_a;
            ex_d.alusrc_b  = id_alusrc_b;
            ex_d.alufun    = id_alufun;
            ex_d.sign      = id_sign;
            ex_d.rd_addr   = id_rd_addr;
            ex_d.regwrite  = id_regwrite;
            ex_d.memread   = id_memread;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_q       <= '0;
            ex_valid_q <= 1'b0;
        end else begin
            ex_q       <= ex_d;
            ex_valid_q <= ex_valid_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else if (id_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;

    // A bubble presents all-zero operands and controls to the ALU and memory stage.
    always_comb begin
        ex_valid      = ex_valid_q;
        alu_a         = '0;
        alu_b         = '0;
        alu_fun       = '0;
        alu_sign      = 1'b0;
        ex_store_data = '0;
        ex_rd_addr    = ex_q.rd_addr;
        ex_regwrite   = 1'b0;
        ex_memread    = 1'b0;
        if (ex_valid_q) begin
            alu_a         = ex_q.alusrc_a ? {{(DATA_W-5){1'b0}}, ex_q.shamt} : fwd_rs;
            alu_b         = ex_q.alusrc_b ? ex_q.imm : fwd_rt;
            alu_fun       = ex_q.alufun;
            alu_sign      = ex_q.sign;
            ex_store_data = fwd_rt;
            ex_regwrite   = ex_q.regwrite;
            ex_memread    = ex_q.memread;
        end
    end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: forwarding priority, register 0, load-use bubble,
// stall hold with operand refresh, flush, async reset and stall counter saturation.
module tb_ex_operand_stage;

    logic        clk;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs_addr;
    logic [4:0]  id_rt_addr;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic [31:0] id_imm;
    logic [4:0]  id_shamt;
    logic        id_alusrc_a;
    logic        id_alusrc_b;
    logic [5:0]  id_alufun;
    logic        id_sign;
    logic [4:0]  id_rd_addr;
    logic        id_regwrite;
    logic        id_memread;
    logic        flush;
    logic        stall_in;
    logic        mem_regwrite;
    logic        mem_memread;
    logic [4:0]  mem_rd_addr;
    logic [31:0] mem_result;
    logic        wb_regwrite;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_result;
    logic        ex_valid;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [5:0]  alu_fun;
    logic        alu_sign;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd_addr;
    logic        ex_regwrite;
    logic        ex_memread;
    logic        id_stall;
    logic [15:0] stall_cnt;

    int checks;
    int errors;

    ex_operand_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_shamt(id_shamt),
        .id_alusrc_a(id_alusrc_a), .id_alusrc_b(id_alusrc_b),
        .id_alufun(id_alufun), .id_sign(id_sign), .id_rd_addr(id_rd_addr),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .flush(flush), .stall_in(stall_in),
        .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
        .mem_rd_addr(mem_rd_addr), .mem_result(mem_result),
        .wb_regwrite(wb_regwrite), .wb_rd_addr(wb_rd_addr), .wb_result(wb_result),
        .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun),
        .alu_sign(alu_sign), .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .id_stall(id_stall), .stall_cnt(stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [4:0] rs, input logic [31:0] rs_d,
                                  input logic [4:0] rt, input logic [31:0] rt_d,
                                  input logic src_a, input logic [4:0] sh,
                                  input logic src_b, input logic [31:0] imm,
                                  input logic [5:0] fun, input logic [4:0] rd,
                                  input logic ld);
        id_valid    = 1'b1;
        id_rs_addr  = rs;
        id_rs_data  = rs_d;
        id_rt_addr  = rt;
        id_rt_data  = rt_d;
        id_alusrc_a = src_a;
        id_shamt    = sh;
        id_alusrc_b = src_b;
        id_imm      = imm;
        id_alufun   = fun;
        id_sign     = 1'b1;
        id_rd_addr  = rd;
        id_regwrite = 1'b1;
        id_memread  = ld;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0;
        id_valid = 0; id_rs_addr = 0; id_rt_addr = 0; id_rs_data = 0; id_rt_data = 0;
        id_imm = 0; id_shamt = 0; id_alusrc_a = 0; id_alusrc_b = 0; id_alufun = 0;
        id_sign = 0; id_rd_addr = 0; id_regwrite = 0; id_memread = 0;
        flush = 0; stall_in = 0;
        mem_regwrite = 0; mem_memread = 0; mem_rd_addr = 0; mem_result = 0;
        wb_regwrite = 0; wb_rd_addr = 0; wb_result = 0;
        tick();
        tick();
        check_output("reset_ex_valid", 32'(ex_valid), 32'd0);
        check_output("reset_alu_fun", 32'(alu_fun), 32'd0);
        check_output("reset_stall_cnt", 32'(stall_cnt), 32'd0);
        check_output("reset_id_stall", 32'(id_stall), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // MEM and WB both write r5: MEM wins, WB value still captured at ID
        mem_regwrite = 1; mem_rd_addr = 5; mem_result = 32'h1234;
        wb_regwrite = 1; wb_rd_addr = 5; wb_result = 32'hBEEF;
        apply_stimulus(5'd5, 32'h0, 5'd6, 32'h10, 0, 5'd0, 0, 32'h0, 6'h01, 5'd7, 0);
        tick();
        check_output("mem_prio_valid", 32'(ex_valid), 32'd1);
        check_output("mem_prio_alu_a", alu_a, 32'h1234);
        check_output("mem_prio_alu_b", alu_b, 32'h10);
        check_output("mem_prio_fun", 32'(alu_fun), 32'h01);
        check_output("mem_prio_sign", 32'(alu_sign), 32'd1);
        check_output("mem_prio_rd", 32'(ex_rd_addr), 32'd7);
        check_output("mem_prio_regwrite", 32'(ex_regwrite), 32'd1);
        mem_regwrite = 0; wb_result = 32'hCAFE;
        #1;
        check_output("wb_fwd_alu_a", alu_a, 32'hCAFE);
        wb_regwrite = 0;
        #1;
        check_output("capture_bypass_alu_a", alu_a, 32'hBEEF);

        // Register 0 is never forwarded, then a shift uses shamt on A
        mem_regwrite = 1; mem_rd_addr = 0; mem_result = 32'hFFFF;
        wb_regwrite = 1; wb_rd_addr = 0; wb_result = 32'hDEAD;
        apply_stimulus(5'd0, 32'h0, 5'd2, 32'h3, 0, 5'd0, 0, 32'h0, 6'h01, 5'd4, 0);
        tick();
        check_output("r0_alu_a", alu_a, 32'h0);
        check_output("r0_alu_b", alu_b, 32'h3);
        apply_stimulus(5'd0, 32'h0, 5'd1, 32'h1, 1, 5'd4, 0, 32'h0, 6'h20, 5'd4, 0);
        tick();
        check_output("sll_alu_a", alu_a, 32'h4);
        check_output("sll_alu_b", alu_b, 32'h1);

        // Immediate on B, store data still carries rt
        mem_regwrite = 0; wb_regwrite = 0;
        apply_stimulus(5'd3, 32'h100, 5'd9, 32'h55, 0, 5'd0, 1, 32'hFFFF_FFF0, 6'h01, 5'd9, 0);
        tick();
        check_output("imm_alu_a", alu_a, 32'h100);
        check_output("imm_alu_b", alu_b, 32'hFFFF_FFF0);
        check_output("imm_store_data", ex_store_data, 32'h55);

        // Load-use: lw r8 in EX, add rs=8 in ID
        apply_stimulus(5'd1, 32'h200, 5'd0, 32'h0, 0, 5'd0, 1, 32'h4, 6'h00, 5'd8, 1);
        tick();
        check_output("lw_memread", 32'(ex_memread), 32'd1);
        apply_stimulus(5'd8, 32'h0, 5'd2, 32'h5, 0, 5'd0, 0, 32'h0, 6'h01, 5'd10, 0);
        #1;
        check_output("lu_id_stall", 32'(id_stall), 32'd1);
        tick();
        check_output("lu_bubble_valid", 32'(ex_valid), 32'd0);
        check_output("lu_bubble_regwrite", 32'(ex_regwrite), 32'd0);
        check_output("lu_bubble_alu_b", alu_b, 32'h0);
        check_output("lu_stall_released", 32'(id_stall), 32'd0);
        check_output("lu_stall_cnt", 32'(stall_cnt), 32'd1);
        mem_regwrite = 1; mem_memread = 1; mem_rd_addr = 8; mem_result = 32'h204;
        tick();
        mem_regwrite = 0; mem_memread = 0;
        wb_regwrite = 1; wb_rd_addr = 8; wb_result = 32'hABCD;
        #1;
        check_output("lu_add_valid", 32'(ex_valid), 32'd1);
        check_output("lu_add_alu_a", alu_a, 32'hABCD);
        check_output("lu_add_alu_b", alu_b, 32'h5);
        mem_regwrite = 1; mem_memread = 1; mem_rd_addr = 8; mem_result = 32'h999;
        #1;
        check_output("mem_load_not_fwd", alu_a, 32'hABCD);
        mem_memread = 0;
        #1;
        check_output("mem_alu_fwd", alu_a, 32'h999);

        // stall_in hold while WB r9 retires
        mem_regwrite = 0; wb_regwrite = 0;
        apply_stimulus(5'd9, 32'h0, 5'd2, 32'h1, 0, 5'd0, 0, 32'h0, 6'h01, 5'd11, 0);
        tick();
        check_output("hold_pre_alu_a", alu_a, 32'h0);
        stall_in = 1;
        apply_stimulus(5'd3, 32'h33, 5'd2, 32'h1, 0, 5'd0, 0, 32'h0, 6'h01, 5'd12, 0);
        wb_regwrite = 1; wb_rd_addr = 9; wb_result = 32'h77;
        #1;
        check_output("hold_id_stall", 32'(id_stall), 32'd1);
        tick();
        wb_regwrite = 0;
        #1;
        check_output("hold_refresh_alu_a", alu_a, 32'h77);
        tick();
        tick();
        check_output("hold_rd", 32'(ex_rd_addr), 32'd11);
        check_output("hold_stall_cnt", 32'(stall_cnt), 32'd4);
        stall_in = 0;
        #1;
        check_output("release_alu_a", alu_a, 32'h77);
        check_output("release_id_stall", 32'(id_stall), 32'd0);
        tick();
        check_output("after_hold_rd", 32'(ex_rd_addr), 32'd12);
        check_output("after_hold_alu_a", alu_a, 32'h33);

        // flush beats stall_in
        apply_stimulus(5'd1, 32'h1, 5'd2, 32'h2, 0, 5'd0, 0, 32'h0, 6'h01, 5'd13, 0);
        flush = 1; stall_in = 1;
        #1;
        check_output("flush_id_stall", 32'(id_stall), 32'd1);
        tick();
        check_output("flush_valid", 32'(ex_valid), 32'd0);
        check_output("flush_regwrite", 32'(ex_regwrite), 32'd0);
        check_output("flush_stall_cnt", 32'(stall_cnt), 32'd5);
        flush = 0; stall_in = 0;
        tick();
        check_output("post_flush_valid", 32'(ex_valid), 32'd1);
        check_output("post_flush_rd", 32'(ex_rd_addr), 32'd13);

        // Asynchronous reset mid-stream
        #2;
        reset = 1'b0;
        #1;
        check_output("async_rst_valid", 32'(ex_valid), 32'd0);
        check_output("async_rst_alu_a", alu_a, 32'h0);
        check_output("async_rst_alu_fun", 32'(alu_fun), 32'd0);
        check_output("async_rst_stall_cnt", 32'(stall_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_output("rst_release_valid", 32'(ex_valid), 32'd0);
        tick();
        check_output("first_capture_valid", 32'(ex_valid), 32'd1);

        // Stall counter saturation
        id_valid = 0;
        stall_in = 1;
        repeat (65534) tick();
        check_output("cnt_near_sat", 32'(stall_cnt), 32'hFFFE);
        repeat (4) tick();
        check_output("cnt_saturated", 32'(stall_cnt), 32'hFFFF);
        stall_in = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
